uart_tx_sched: RTL

UART transmit scheduler that shares the single UART TX data register between two byte-stream requesters: the core store path (m0) and the student-ID output engine (m1). It arbitrates requests, buffers accepted bytes in a small FIFO, and drains them to the UART over the rib write port, pacing on the UART busy flag. It sits between ex/sid and rib, replacing direct UART writes from the sID engine.

---
 rtl/uart_tx_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched -- shares the single UART TX data register between the core
// store path (m0) and the student-ID output engine (m1).
//
// Requests are arbitrated, accepted bytes are buffered in a small FIFO, and a
// drain FSM (IDLE -> WRITE -> GAP) writes each byte to the UART over the rib
// write port. The FSM only pops while the UART reports idle.
//
// Optional feature macro: UART_TX_SCHED_RR_EN
//   defined   : round-robin arbitration. A 1-bit last-grant register, reset
//               to m1, hands each tie to the requester not granted last.
//   undefined : fixed priority, m0 wins every tie.
//
// Parameters:
//   FIFO_DEPTH  FIFO entries (power of two, >= 2)
//   TX_ADDR     rib address of the UART TX data register
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   m0_req_i/data_i     core byte request / byte;  m0_ack_o accepted this cycle
//   m1_req_i/data_i     sID byte request / byte;   m1_ack_o accepted this cycle
//   uart_busy_i         UART is shifting a byte out
//   uart_we_o           rib write strobe, one cycle per byte (registered)
//   uart_waddr_o        rib write address (TX_ADDR during WRITE, else 0)
//   uart_wdata_o        byte zero-extended to 32 bits (0 outside WRITE)
//   fifo_full_o         FIFO holds FIFO_DEPTH bytes
//   fifo_empty_o        FIFO holds no bytes
//   busy_o              FIFO non-empty or drain FSM not idle
module uart_tx_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] TX_ADDR    = 32'h3000_000C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [7:0]  m0_data_i,
    output logic        m0_ack_o,
    input  logic        m1_req_i,
    input  logic [7:0]  m1_data_i,
    output logic        m1_ack_o,
    input  logic        uart_busy_i,
    output logic        uart_we_o,
    output logic [31:0] uart_waddr_o,
    output logic [31:0] uart_wdata_o,
    output logic        fifo_full_o,
    output logic        fifo_empty_o,
    output logic        busy_o
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;

    logic           grant0, grant1, push, pop;
    logic [7:0]     push_data;
    logic           we_nx;
    logic [31:0]    waddr_nx, wdata_nx;

`ifdef UART_TX_SCHED_RR_EN
    logic           last_m1;    // 1: m1 was granted most recently
`endif

    assign fifo_full_o  = (count == DEPTH_C);
    assign fifo_empty_o = (count == '0);
    assign busy_o       = !fifo_empty_o || (state != IDLE);

    // Arbitration; acks stay low while in reset or while full, even if a pop
    // frees a slot on the same edge.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && !fifo_full_o) begin
            if (m0_req_i && m1_req_i) begin
`ifdef UART_TX_SCHED_RR_EN
                grant0 = last_m1;
                grant1 = !last_m1;
`else
                grant0 = 1'b1;
`endif
            end else begin
                grant0 = m0_req_i;
                grant1 = m1_req_i;
            end
        end
    end

    assign m0_ack_o  = grant0;
    assign m1_ack_o  = grant1;
    assign push      = grant0 || grant1;
    assign push_data = grant0 ? m0_data_i : m1_data_i;

    // Drain FSM next state and next values of the registered rib outputs.
    // The head byte is popped on the IDLE->WRITE edge, so the strobe register
    // is loaded on that same edge and is high exactly for the WRITE cycle.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        we_nx    = 1'b0;
        waddr_nx = '0;
        wdata_nx = '0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty_o && !uart_busy_i) begin
                    pop      = 1'b1;
                    we_nx    = 1'b1;
                    waddr_nx = TX_ADDR;
                    wdata_nx = {24'h0, mem[rd_ptr]};
                    state_nx = WRITE;
                end
            end
            WRITE:   state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage needs no reset: contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            uart_we_o    <= 1'b0;
            uart_waddr_o <= '0;
            uart_wdata_o <= '0;
        end else begin
            state        <= state_nx;
            uart_we_o    <= we_nx;
            uart_waddr_o <= waddr_nx;
            uart_wdata_o <= wdata_nx;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef UART_TX_SCHED_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_m1 <= 1'b1;
        end else if (push) begin
            last_m1 <= grant1;
        end
    end
`endif

endmodule
